// File: rtl/cic_pkg.sv
// Shared definitions for the PCM-to-UART streaming path.
// Contents: sync byte, bytes per frame, UART FSM state type, and a helper
// that picks one byte out of a frame word (byte 0 is the most significant).
package cic_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  function automatic logic [7:0] frame_byte(input logic [8*FRAME_BYTES-1:0] frame,
                                            input logic [1:0]               idx);
    return frame[8*(FRAME_BYTES-1-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/pcm_uart_tx_if.sv
// Sample-in / UART-out bundle for pcm_uart_tx.
//   in_stb, in_val : sample strobe and value from the CIC decimator
//   tx, busy       : UART serial line (idle high) and frame-in-progress flag
//   level          : FIFO occupancy
//   overflow       : sticky sample-dropped flag
// master = sample source / observer, slave = pcm_uart_tx.
interface pcm_uart_tx_if #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             in_stb;
  logic [WIDTH-1:0] in_val;
  logic             tx;
  logic             busy;
  logic [LW-1:0]    level;
  logic             overflow;

  modport master (output in_stb, in_val, input tx, busy, level, overflow);
  modport slave  (input in_stb, in_val, output tx, busy, level, overflow);
endinterface

// File: rtl/pcm_uart_tx_fifo.sv
// Synchronous FIFO with first-word-fall-through read.
//   clk, reset : clock, asynchronous active-high reset
//   wr_en      : write request; accepted when not full or when a read
//                happens on the same edge
//   wr_data    : write data
//   rd_en      : read request; ignored when empty
//   rd_data    : head entry, valid whenever empty is low
//   full/empty : occupancy flags
//   level      : occupancy count (0..DEPTH)
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == FULL_LVL);
  assign empty   = (count == '0);
  assign level   = count;
  assign rd_data = mem[rd_ptr];

  assign do_rd = rd_en && !empty;
  // A read on the same edge frees the slot the write needs.
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pcm_uart_tx.sv
// Streams decimated PCM samples off-chip as 8N1 UART frames.
// Each sample becomes a 4-byte frame: 0xA5, then sample bits [23:16],
// [15:8], [7:0]; every byte is sent LSB first.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : sample strobe/value in; tx, busy, level, overflow out
//
//   state | meaning
//   IDLE  | line high, waiting for a buffered sample
//   START | start bit (low) of the current byte
//   DATA  | data bits of the current byte, LSB first
//   STOP  | stop bit (high); then next byte, next frame, or IDLE
module pcm_uart_tx
  import cic_pkg::*;
#(
  parameter int WIDTH        = 24,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         reset,
  pcm_uart_tx_if.slave bus
);
  localparam int FW = 8 * FRAME_BYTES;
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]    LAST_BYTE = 2'(FRAME_BYTES - 1);

  uart_state_t       state, nxt_state;
  logic [CW-1:0]     baud_cnt, nxt_baud;
  logic [2:0]        bit_idx, nxt_bit;
  logic [1:0]        byte_idx, nxt_byte;
  logic [FW-1:0]     frame, nxt_frame;
  logic              tx_r, nxt_tx;
  logic              busy_r, nxt_busy;
  logic              ovf_r;

  logic              pop;
  logic              baud_done;
  logic [7:0]        cur_byte;
  logic [2:0]        bit_inc;
  logic [WIDTH-1:0]  head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [$clog2(DEPTH):0] fifo_level;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.in_stb),
    .wr_data (bus.in_val),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign baud_done = (baud_cnt == '0);
  assign cur_byte  = frame_byte(frame, byte_idx);
  assign bit_inc   = bit_idx + 3'd1;

  always_comb begin
    nxt_state = state;
    nxt_baud  = baud_cnt;
    nxt_bit   = bit_idx;
    nxt_byte  = byte_idx;
    nxt_frame = frame;
    nxt_tx    = tx_r;
    nxt_busy  = busy_r;
    pop       = 1'b0;

    case (state)
      IDLE: begin
        nxt_tx   = 1'b1;
        nxt_busy = 1'b0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          nxt_frame = {SYNC_BYTE, head};
          nxt_byte  = '0;
          nxt_baud  = BAUD_LOAD;
          nxt_state = START;
          nxt_tx    = 1'b0;
          nxt_busy  = 1'b1;
        end
      end
      START: begin
        if (baud_done) begin
          nxt_state = DATA;
          nxt_bit   = '0;
          nxt_baud  = BAUD_LOAD;
          nxt_tx    = cur_byte[0];
        end else begin
          nxt_baud = baud_cnt - 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          nxt_baud = BAUD_LOAD;
          if (bit_idx == 3'd7) begin
            nxt_state = STOP;
            nxt_tx    = 1'b1;
          end else begin
            nxt_bit = bit_inc;
            nxt_tx  = cur_byte[bit_inc];
          end
        end else begin
          nxt_baud = baud_cnt - 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          if (byte_idx != LAST_BYTE) begin
            nxt_byte  = byte_idx + 2'd1;
            nxt_baud  = BAUD_LOAD;
            nxt_state = START;
            nxt_tx    = 1'b0;
          end else if (!fifo_empty) begin
            // Back-to-back frame: reload straight into START, no idle bit.
            pop       = 1'b1;
            nxt_frame = {SYNC_BYTE, head};
            nxt_byte  = '0;
            nxt_baud  = BAUD_LOAD;
            nxt_state = START;
            nxt_tx    = 1'b0;
          end else begin
            nxt_state = IDLE;
            nxt_tx    = 1'b1;
            nxt_busy  = 1'b0;
          end
        end else begin
          nxt_baud = baud_cnt - 1'b1;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_tx    = 1'b1;
        nxt_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      frame    <= '0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      state    <= nxt_state;
      baud_cnt <= nxt_baud;
      bit_idx  <= nxt_bit;
      byte_idx <= nxt_byte;
      frame    <= nxt_frame;
      tx_r     <= nxt_tx;
      busy_r   <= nxt_busy;
    end
  end

  // Sample lost: strobe while full with no pop freeing a slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  ovf_r <= 1'b0;
    else if (bus.in_stb && fifo_full && !pop)   ovf_r <= 1'b1;
  end

  assign bus.tx       = tx_r;
  assign bus.busy     = busy_r;
  assign bus.level    = fifo_level;
  assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_pcm_uart_tx.sv
// Directed bench for pcm_uart_tx with CLKS_PER_BIT=4, DEPTH=4.
// A background receiver decodes tx into 10-bit words {stop, data, start}.
module tb_pcm_uart_tx;
  localparam int WIDTH = 24;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;

  logic clk;
  logic rst;

  pcm_uart_tx_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pcm_uart_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [9:0] rxq[$];
  logic [9:0] mon_w;
  bit         rst_seen;

  always @(posedge rst) rst_seen = 1'b1;

  // Receiver: start edge seen at a falling clock edge, bits sampled 2 cycles
  // into each bit period. Words overlapping a reset are discarded.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.tx === 1'b0) begin
        rst_seen = 1'b0;
        repeat (2) @(negedge clk);
        mon_w[0] = bus.tx;
        for (int i = 1; i < 10; i++) begin
          repeat (CPB) @(negedge clk);
          mon_w[i] = bus.tx;
        end
        if (!rst_seen) rxq.push_back(mon_w);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input logic [23:0] v, input string tag);
    logic [7:0] b [4];
    logic [9:0] w;
    int n;
    b[0] = 8'hA5;
    b[1] = v[23:16];
    b[2] = v[15:8];
    b[3] = v[7:0];
    n = 0;
    while (rxq.size() < 4 && n < 400) begin
      step();
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      if (rxq.size() == 0) begin
        check($sformatf("%s_byte%0d_timeout", tag, i), 32'hFFFF_FFFF, {22'd0, 1'b1, b[i], 1'b0});
      end else begin
        w = rxq.pop_front();
        check($sformatf("%s_byte%0d", tag, i), {22'd0, w}, {22'd0, 1'b1, b[i], 1'b0});
      end
    end
  endtask

  int cnt;
  int run;
  int maxlvl;
  bit seen_low;
  int lv_exp [6] = '{1, 1, 2, 3, 4, 4};
  logic [23:0] t6_vals [6] = '{24'hA1B2C3, 24'h0F0F0F, 24'h55AA55,
                               24'h7FFFFF, 24'hC0FFEE, 24'h3C5A96};

  initial begin
    rst        = 1'b1;
    bus.in_stb = 1'b0;
    bus.in_val = '0;
    #1;
    check("rst_tx", 32'(bus.tx), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step();

    // Single sample: latency, busy length, byte content.
    bus.in_stb = 1'b1;
    bus.in_val = 24'h123456;
    step();
    bus.in_stb = 1'b0;
    check("t2_level_push", 32'(bus.level), 32'd1);
    check("t2_tx_before_pop", 32'(bus.tx), 32'd1);
    step();
    check("t2_tx_start", 32'(bus.tx), 32'd0);
    check("t2_busy_start", 32'(bus.busy), 32'd1);
    check("t2_level_pop", 32'(bus.level), 32'd0);
    cnt = 0;
    while (bus.busy && cnt < 300) begin
      cnt++;
      step();
    end
    check("t2_busy_cycles", 32'(cnt), 32'd160);
    check("t2_tx_idle", 32'(bus.tx), 32'd1);
    expect_frame(24'h123456, "t2");

    // Negative sample passes bit-exact.
    repeat (5) step();
    bus.in_stb = 1'b1;
    bus.in_val = 24'h800001;
    step();
    bus.in_stb = 1'b0;
    expect_frame(24'h800001, "t3");
    repeat (10) step();
    check("t3_busy_end", 32'(bus.busy), 32'd0);

    // Two strobes 10 cycles apart: frames back-to-back, one busy run.
    bus.in_stb = 1'b1;
    bus.in_val = 24'h000001;
    step();
    bus.in_stb = 1'b0;
    step();
    run = 0;
    maxlvl = 0;
    seen_low = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (bus.busy && !seen_low) run++;
      else seen_low = 1'b1;
      if (int'(bus.level) > maxlvl) maxlvl = int'(bus.level);
      if (k == 8) begin
        bus.in_stb = 1'b1;
        bus.in_val = 24'hFFFFFF;
      end else begin
        bus.in_stb = 1'b0;
      end
      step();
    end
    check("t4_busy_run", 32'(run), 32'd320);
    check("t4_level_peak", 32'(maxlvl), 32'd1);
    check("t4_tx_idle", 32'(bus.tx), 32'd1);
    expect_frame(24'h000001, "t4a");
    expect_frame(24'hFFFFFF, "t4b");

    // Six consecutive strobes: fills to 4, sixth dropped.
    for (int v = 1; v <= 6; v++) begin
      bus.in_stb = 1'b1;
      bus.in_val = 24'(v);
      step();
      check($sformatf("t5_level_%0d", v), 32'(bus.level), 32'(lv_exp[v-1]));
      check($sformatf("t5_ovf_%0d", v), 32'(bus.overflow), (v == 6) ? 32'd1 : 32'd0);
    end
    bus.in_stb = 1'b0;
    repeat (10) step();
    check("t5_ovf_sticky", 32'(bus.overflow), 32'd1);
    for (int v = 1; v <= 5; v++) expect_frame(24'(v), $sformatf("t5_f%0d", v));
    repeat (10) step();
    check("t5_ovf_still", 32'(bus.overflow), 32'd1);
    check("t5_level_drained", 32'(bus.level), 32'd0);

    // Reset mid-frame with data buffered and overflow set.
    for (int v = 0; v < 3; v++) begin
      bus.in_stb = 1'b1;
      bus.in_val = 24'h010203 + 24'(v);
      step();
    end
    bus.in_stb = 1'b0;
    repeat (30) step();
    check("t1_pre_busy", 32'(bus.busy), 32'd1);
    check("t1_pre_level", 32'(bus.level), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("t1_async_tx", 32'(bus.tx), 32'd1);
    check("t1_async_busy", 32'(bus.busy), 32'd0);
    check("t1_async_level", 32'(bus.level), 32'd0);
    check("t1_async_ovf", 32'(bus.overflow), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("t1_held_tx", 32'(bus.tx), 32'd1);
    rst = 1'b0;
    repeat (50) step();
    check("t1_after_tx", 32'(bus.tx), 32'd1);
    check("t1_after_busy", 32'(bus.busy), 32'd0);
    rxq.delete();

    // Full FIFO, strobe lands on the edge the frame's last stop bit ends.
    for (int v = 0; v < 5; v++) begin
      bus.in_stb = 1'b1;
      bus.in_val = t6_vals[v];
      step();
      check($sformatf("t6_level_%0d", v), 32'(bus.level), 32'(lv_exp[v]));
    end
    bus.in_stb = 1'b0;
    repeat (156) step();
    check("t6_pre_level", 32'(bus.level), 32'd4);
    check("t6_pre_tx_stop", 32'(bus.tx), 32'd1);
    check("t6_pre_busy", 32'(bus.busy), 32'd1);
    bus.in_stb = 1'b1;
    bus.in_val = t6_vals[5];
    step();
    bus.in_stb = 1'b0;
    check("t6_level_same", 32'(bus.level), 32'd4);
    check("t6_ovf_clear", 32'(bus.overflow), 32'd0);
    check("t6_tx_next_start", 32'(bus.tx), 32'd0);
    check("t6_busy_cont", 32'(bus.busy), 32'd1);
    for (int v = 0; v < 6; v++) expect_frame(t6_vals[v], $sformatf("t6_f%0d", v));
    repeat (10) step();
    check("t6_ovf_end", 32'(bus.overflow), 32'd0);
    check("t6_idle_end", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
